// File: rtl/key_schedule_gen.sv
`default_nettype none
// ============================================================================
// key_schedule_gen : word-serial AES key expansion into a stored schedule,
//   with an indexed, registered round-key read port.
//   Optional feature macro: KEY_SCHED_REVERSE_EN (rk_reverse port).
// Revision: 1.0
// ============================================================================
module key_schedule_gen #(
  parameter int NK = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         sched_valid,
  input  logic [3:0]   rk_index,
`ifdef KEY_SCHED_REVERSE_EN
  input  logic         rk_reverse,
`endif
  output logic [127:0] round_key
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] c_NK         = 6'(NK);
  localparam logic [5:0] c_NW         = 6'(NW);
  localparam logic [3:0] c_NR         = 4'(NR);
  localparam logic [2:0] c_PHASE_LAST = 3'(NK - 1);

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Entry x sits at bits [2047-8x -: 8]; 2047-8x is {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return c_SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_t      r_state;
  logic [31:0] r_w [NW];
  logic [5:0]  r_i;
  logic [2:0]  r_phase;   // tracks i mod NK without a divider
  logic [7:0]  r_rcon;

  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_next;
  logic        w_accept;
  logic [3:0]  w_sel;
  logic        w_unused_key;

  assign w_accept     = key_valid && key_ready;
  assign w_unused_key = ^key_in;

  // One SubWord unit serves both the rotated and the NK=8 mid-block cases.
  always_comb begin
    w_prev   = r_w[r_i - 6'd1];
    w_back   = r_w[r_i - c_NK];
    w_sub_in = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = sub_word(w_sub_in);
    if (r_phase == 3'd0) begin
      w_t = w_sub ^ {r_rcon, 24'h0};
    end else if ((NK == 8) && (r_phase == 3'd4)) begin
      w_t = w_sub;
    end else begin
      w_t = w_prev;
    end
    w_next = w_back ^ w_t;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      key_ready   <= 1'b1;
      busy        <= 1'b0;
      sched_valid <= 1'b0;
      r_i         <= '0;
      r_phase     <= '0;
      r_rcon      <= 8'h01;
      for (int k = 0; k < NW; k++) begin
        r_w[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            for (int k = 0; k < NK; k++) begin
              r_w[k] <= key_in[255 - 32*k -: 32];
            end
            r_i         <= c_NK;
            r_phase     <= '0;
            r_rcon      <= 8'h01;
            r_state     <= S_EXPAND;
            key_ready   <= 1'b0;
            busy        <= 1'b1;
            sched_valid <= 1'b0;
          end
        end
        S_EXPAND: begin
          // The cycle after the last word lands is spent publishing DONE.
          if (r_i == c_NW) begin
            r_state     <= S_DONE;
            key_ready   <= 1'b1;
            busy        <= 1'b0;
            sched_valid <= 1'b1;
          end else begin
            r_w[r_i] <= w_next;
            r_i      <= r_i + 6'd1;
            r_phase  <= (r_phase == c_PHASE_LAST) ? 3'd0 : r_phase + 3'd1;
            if (r_phase == 3'd0) begin
              r_rcon <= xtime(r_rcon);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
`ifdef KEY_SCHED_REVERSE_EN
    w_sel = rk_reverse ? (c_NR - rk_index) : rk_index;
`else
    w_sel = rk_index;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      round_key <= '0;
    end else if (rk_index > c_NR) begin
      round_key <= '0;
    end else begin
      round_key <= {r_w[{w_sel, 2'b00}], r_w[{w_sel, 2'b01}],
                    r_w[{w_sel, 2'b10}], r_w[{w_sel, 2'b11}]};
    end
  end

endmodule
`default_nettype wire
